// File: rtl/pcs_pkg.sv
// Shared PCS transmit definitions: one-hot ordered sets, K-code octets and
// the ordered-set sequencer state encoding.
package pcs_pkg;

  localparam logic [4:0] OS_R = 5'b00001;
  localparam logic [4:0] OS_S = 5'b00010;
  localparam logic [4:0] OS_T = 5'b00100;
  localparam logic [4:0] OS_D = 5'b01000;
  localparam logic [4:0] OS_I = 5'b10000;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;

  typedef enum logic [2:0] {
    IDLE_A,
    IDLE_B,
    SOP,
    DATA,
    EOP_T,
    EPD_R1,
    EPD_R2
  } seq_state_t;

  function automatic logic [4:0] o_set_of(input seq_state_t s);
    case (s)
      SOP:            return OS_S;
      DATA:           return OS_D;
      EOP_T:          return OS_T;
      EPD_R1, EPD_R2: return OS_R;
      default:        return OS_I;
    endcase
  endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating up-counter with synchronous clear.
module pcs_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pcs_tx_ordered_set_sequencer.sv
// PCS transmit ordered-set sequencer (I/S/D/T/R) feeding the 8b/10b encoder.
// Define PCS_TX_STATS_EN to add saturating packet/drop statistics counters.
module pcs_tx_ordered_set_sequencer
  import pcs_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             mr_main_reset,
  input  logic             TX_EN,
  input  logic [7:0]       TXD,
  output logic [4:0]       tx_o_set,
  output logic [7:0]       tx_txd,
  output logic             tx_pos_odd,
  output logic             transmitting
`ifdef PCS_TX_STATS_EN
  ,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count
`endif
);

  seq_state_t state;

  // Parity is a free-running toggle; the FSM keeps IDLE_A and SOP on even slots.
  always_ff @(posedge clk) begin
    if (mr_main_reset) begin
      state      <= IDLE_A;
      tx_txd     <= K28_5;
      tx_pos_odd <= 1'b0;
    end else begin
      tx_pos_odd <= ~tx_pos_odd;
      case (state)
        IDLE_A: begin
          state  <= IDLE_B;
          tx_txd <= K28_5;
        end
        IDLE_B: begin
          if (TX_EN) begin
            state  <= SOP;
            tx_txd <= K27_7;
          end else begin
            state  <= IDLE_A;
            tx_txd <= K28_5;
          end
        end
        SOP, DATA: begin
          if (TX_EN) begin
            state  <= DATA;
            tx_txd <= TXD;
          end else begin
            state  <= EOP_T;
            tx_txd <= K29_7;
          end
        end
        EOP_T: begin
          state  <= EPD_R1;
          tx_txd <= K23_7;
        end
        EPD_R1: begin
          // An /R/ on an even slot needs a second /R/ so idles restart even.
          if (tx_pos_odd) begin
            state  <= IDLE_A;
            tx_txd <= K28_5;
          end else begin
            state  <= EPD_R2;
            tx_txd <= K23_7;
          end
        end
        default: begin
          state  <= IDLE_A;
          tx_txd <= K28_5;
        end
      endcase
    end
  end

  assign tx_o_set     = o_set_of(state);
  assign transmitting = (state != IDLE_A) && (state != IDLE_B);

`ifdef PCS_TX_STATS_EN
  logic pkt_inc;
  logic drop_inc;

  assign pkt_inc  = TX_EN && (state == IDLE_B);
  assign drop_inc = TX_EN && ((state == IDLE_A) || (state == EOP_T) ||
                              (state == EPD_R1) || (state == EPD_R2));

  pcs_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .clear (mr_main_reset),
    .inc   (pkt_inc),
    .count (pkt_count)
  );

  pcs_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .clear (mr_main_reset),
    .inc   (drop_inc),
    .count (drop_count)
  );
`else
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_pcs_tx_ordered_set_sequencer.sv
// Self-checking bench: directed scenarios plus random TX_EN/TXD traffic
// compared against an output-stream reference model.
module tb_pcs_tx_ordered_set_sequencer;
  import pcs_pkg::*;

  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    d;
  logic [4:0]    tx_o_set;
  logic [7:0]    tx_txd;
  logic          tx_pos_odd;
  logic          transmitting;
`ifdef PCS_TX_STATS_EN
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] drop_count;
`endif

  pcs_tx_ordered_set_sequencer #(.CNT_W(CW)) dut (
    .clk           (clk),
    .mr_main_reset (rst),
    .TX_EN         (en),
    .TXD           (d),
    .tx_o_set      (tx_o_set),
    .tx_txd        (tx_txd),
    .tx_pos_odd    (tx_pos_odd),
    .transmitting  (transmitting)
`ifdef PCS_TX_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] o;
    logic [7:0] t;
  } sym_t;

  // Reference model: expected symbol stream, built from the ordered-set rules.
  logic [4:0] m_oset;
  logic [7:0] m_txd;
  logic       m_odd;
  int         m_pkt;
  int         m_drop;
  sym_t       q[$];
  int         n_chk;
  int         n_fail;
  int         saw_d_single;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic prev_in;
    logic prev_idle_odd;
    logic nodd;
    sym_t s;
    if (rst) begin
      m_oset = OS_I; m_txd = K28_5; m_odd = 1'b0;
      m_pkt = 0; m_drop = 0; q.delete();
    end else begin
      prev_in       = (m_oset == OS_S) || (m_oset == OS_D);
      prev_idle_odd = (m_oset == OS_I) && m_odd;
      nodd          = ~m_odd;
      if (en && !prev_in && !prev_idle_odd && m_drop != SAT) m_drop++;
      if (q.size() > 0) begin
        s = q.pop_front();
        m_oset = s.o; m_txd = s.t;
      end else if (prev_in) begin
        if (en) begin
          m_oset = OS_D; m_txd = d;
        end else begin
          m_oset = OS_T; m_txd = K29_7;
          s.o = OS_R; s.t = K23_7;
          q.push_back(s);
          // T on an odd slot puts the first R on an even slot: one more R.
          if (nodd) q.push_back(s);
        end
      end else if (prev_idle_odd && en) begin
        m_oset = OS_S; m_txd = K27_7;
        if (m_pkt != SAT) m_pkt++;
      end else begin
        m_oset = OS_I; m_txd = K28_5;
      end
      m_odd = nodd;
    end
  endtask

  task automatic check_all();
    chk("o_set", 32'(tx_o_set), 32'(m_oset));
    chk("txd", 32'(tx_txd), 32'(m_txd));
    chk("pos_odd", 32'(tx_pos_odd), 32'(m_odd));
    chk("transmitting", 32'(transmitting), 32'(m_oset != OS_I));
`ifdef PCS_TX_STATS_EN
    chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  endtask

  task automatic step(input logic e, input logic [7:0] v);
    en = e;
    d  = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (tx_o_set == OS_D) saw_d_single++;
  endtask

  // Idle until the current symbol is I at the requested parity (bounded).
  task automatic align(input logic want_odd);
    int k;
    k = 0;
    while (!(m_oset == OS_I && m_odd == want_odd) && k < 16) begin
      step(1'b0, 8'h00);
      k++;
    end
    n_chk++;
    assert (k < 16) else begin
      n_fail++;
      $error("FAIL align_timeout observed=%0d expected=<16", k);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; saw_d_single = 0;
    rst = 1'b1; en = 1'b0; d = 8'h00;
    m_oset = OS_I; m_txd = K28_5; m_odd = 1'b0; m_pkt = 0; m_drop = 0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);

    // Preamble-style packet entering in IDLE_B.
    align(1'b1);
    step(1'b1, 8'h55); step(1'b1, 8'h55); step(1'b1, 8'hD5);
    step(1'b1, 8'h01); step(1'b1, 8'h02);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    // TX_EN rising in IDLE_A: that octet is dropped.
    align(1'b0);
    step(1'b1, 8'h55); step(1'b1, 8'h55); step(1'b1, 8'hA1); step(1'b1, 8'hA2);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    // Back-to-back packets separated by a single low clock.
    align(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i));
    step(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    // Reset in DATA: no T or R follows.
    align(1'b1);
    step(1'b1, 8'h55); step(1'b1, 8'h66); step(1'b1, 8'h77);
    rst = 1'b1;
    step(1'b1, 8'h88);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);

    // Single-octet TX_EN in IDLE_B: S,T,R(,R) with no D.
    align(1'b1);
    saw_d_single = 0;
    step(1'b1, 8'hAA);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
    chk("single_no_d", 32'(saw_d_single), 32'd0);

    // Random traffic with bursty TX_EN and occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) en = ~en;
      rst = ($urandom_range(0, 199) == 0);
      step(en, 8'($urandom));
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
